// File: rtl/frame_buffer_arbiter.sv
// Single-port frame buffer arbiter: round-robin over rq/ack requesters, with fixed-priority
// real-time requesters and optional hold-time preemption of non-priority holders.
module frame_buffer_arbiter #(
    parameter int unsigned         NUM_REQ   = 4,
    parameter logic [NUM_REQ-1:0]  PRIO_MASK = 4'b1000,
    parameter int unsigned         MAX_HOLD  = 0,
    parameter int unsigned         IDX_BITS  = $clog2(NUM_REQ)
) (
    input  logic                sobel_clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  rq,
    output logic [NUM_REQ-1:0]  ack,
    output logic                busy,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic [NUM_REQ-1:0]  preempt
);

    localparam int unsigned HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

    state_e              r_state;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_busy;
    logic [IDX_BITS-1:0] r_grant_idx;
    logic [NUM_REQ-1:0]  r_preempt;
    logic [IDX_BITS-1:0] r_rr_ptr;
    logic [HOLD_W-1:0]   r_hold_cnt;

    logic [NUM_REQ-1:0]  w_prio_rq;
    logic [IDX_BITS-1:0] w_winner;
    logic [IDX_BITS-1:0] w_next_ptr;
    logic                w_holder_rq;
    logic                w_others;
    logic                w_preempt;

    // (a + b) mod NUM_REQ for a < NUM_REQ, b < NUM_REQ.
    function automatic logic [IDX_BITS-1:0] wrap_add(input logic [IDX_BITS-1:0] a,
                                                     input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_BITS'(s);
    endfunction

    assign w_prio_rq   = rq & PRIO_MASK;
    assign w_next_ptr  = wrap_add(r_grant_idx, 1);
    assign w_holder_rq = rq[r_grant_idx];
    assign w_others    = (rq & ~r_ack) != '0;
    assign w_preempt   = (MAX_HOLD != 0) && !PRIO_MASK[r_grant_idx] &&
                         (r_hold_cnt == HOLD_LAST) && w_others;

    // Descending scans so the last assignment is the lowest index / nearest to rr_ptr.
    always_comb begin
        w_winner = '0;
        if (w_prio_rq != '0) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (w_prio_rq[i]) w_winner = IDX_BITS'(i);
            end
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                if (rq[wrap_add(r_rr_ptr, unsigned'(k))]) w_winner = wrap_add(r_rr_ptr, unsigned'(k));
            end
        end
    end

    always_ff @(posedge sobel_clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_ack       <= '0;
            r_busy      <= 1'b0;
            r_grant_idx <= '0;
            r_preempt   <= '0;
            r_rr_ptr    <= '0;
            r_hold_cnt  <= '0;
        end else begin
            r_preempt <= '0;
            unique case (r_state)
                StIdle: begin
                    if (rq != '0) begin
                        r_state     <= StGrant;
                        r_busy      <= 1'b1;
                        r_ack       <= NUM_REQ'(1) << w_winner;
                        r_grant_idx <= w_winner;
                        r_hold_cnt  <= '0;
                    end
                end
                StGrant: begin
                    if (r_hold_cnt != '1) r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (!w_holder_rq || w_preempt) begin
                        r_state  <= StTurn;
                        r_ack    <= '0;
                        r_rr_ptr <= w_next_ptr;
                        // A simultaneous voluntary release takes precedence: no pulse.
                        if (w_holder_rq) r_preempt <= r_ack;
                    end
                end
                StTurn: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_ack   <= '0;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign busy      = r_busy;
    assign grant_idx = r_grant_idx;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: directed scenarios plus random rq traffic, every cycle
// compared against a transaction-level reference model of the arbitration rules.
module tb_frame_buffer_arbiter;

    logic       sobel_clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rq = '0;

    logic [3:0] a_ack, a_pre;
    logic       a_busy;
    logic [1:0] a_idx;
    logic [2:0] b_ack, b_pre;
    logic       b_busy;
    logic [1:0] b_idx;

    always #5 sobel_clk = ~sobel_clk;

    frame_buffer_arbiter #(.NUM_REQ(4), .PRIO_MASK(4'b1000), .MAX_HOLD(16)) u_dut (
        .sobel_clk(sobel_clk), .reset(reset), .rq(rq),
        .ack(a_ack), .busy(a_busy), .grant_idx(a_idx), .preempt(a_pre)
    );

    frame_buffer_arbiter #(.NUM_REQ(3), .PRIO_MASK(3'b000), .MAX_HOLD(3)) u_dut_rr (
        .sobel_clk(sobel_clk), .reset(reset), .rq(rq[2:0]),
        .ack(b_ack), .busy(b_busy), .grant_idx(b_idx), .preempt(b_pre)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: holder (-1 = nobody), dead cycles left before arbitration resumes,
    // ack cycles served so far, round-robin start, last holder, pending preempt pulse.
    typedef struct {
        int holder;
        int gap;
        int held;
        int ptr;
        int last;
        int pre;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_step(input mdl_t m, input int unsigned rqv, input bit rst,
                                      input int n, input int unsigned prio, input int maxh);
        mdl_t r;
        r = m;
        r.pre = 0;
        if (rst) begin
            r.holder = -1; r.gap = 0; r.held = 0; r.ptr = 0; r.last = 0;
        end else if (m.holder >= 0) begin
            int  h;
            bit  wants, others, forced;
            h      = m.holder;
            wants  = ((rqv >> h) & 1) != 0;
            others = (rqv & ~(32'd1 << h)) != 0;
            forced = (maxh != 0) && (((prio >> h) & 1) == 0) && (m.held == maxh) && others;
            if (!wants || forced) begin
                if (wants) r.pre = 1 << h;
                r.holder = -1;
                r.gap    = 1;
                r.ptr    = (h + 1) % n;
            end else begin
                r.held = m.held + 1;
            end
        end else if (m.gap > 0) begin
            r.gap = m.gap - 1;
        end else if (rqv != 0) begin
            int w;
            w = -1;
            if ((rqv & prio) != 0) begin
                for (int i = n - 1; i >= 0; i--) if ((((rqv & prio) >> i) & 1) != 0) w = i;
            end else begin
                for (int k = n - 1; k >= 0; k--) if (((rqv >> ((m.ptr + k) % n)) & 1) != 0)
                    w = (m.ptr + k) % n;
            end
            r.holder = w;
            r.held   = 1;
            r.last   = w;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_ack(input mdl_t m);
        return (m.holder >= 0) ? (32'd1 << m.holder) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_busy(input mdl_t m);
        return ((m.holder >= 0) || (m.gap > 0)) ? 32'd1 : 32'd0;
    endfunction

    task automatic tick(input logic [3:0] rq_v, input logic rst_v);
        @(negedge sobel_clk);
        rq    = rq_v;
        reset = rst_v;
        @(posedge sobel_clk);
        ma = mdl_step(ma, {28'd0, rq_v}, rst_v, 4, 32'b1000, 16);
        mb = mdl_step(mb, {29'd0, rq_v[2:0]}, rst_v, 3, 32'b000, 3);
        #1;
        check_eq("a_ack", {28'd0, a_ack}, exp_ack(ma));
        check_eq("a_busy", {31'd0, a_busy}, exp_busy(ma));
        check_eq("a_grant_idx", {30'd0, a_idx}, ma.last);
        check_eq("a_preempt", {28'd0, a_pre}, ma.pre);
        check_eq("b_ack", {29'd0, b_ack}, exp_ack(mb));
        check_eq("b_busy", {31'd0, b_busy}, exp_busy(mb));
        check_eq("b_grant_idx", {30'd0, b_idx}, mb.last);
        check_eq("b_preempt", {29'd0, b_pre}, mb.pre);
    endtask

    initial begin
        int          n_ack;
        int          hold[4];
        int          order[$];
        logic [3:0]  prev_ack;
        logic [3:0]  v;
        int unsigned slow;
        bit          saw_pre;

        ma = '{-1, 0, 0, 0, 0, 0};
        mb = '{-1, 0, 0, 0, 0, 0};
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);

        // Single requester, then release.
        for (int c = 0; c < 5; c++) tick(4'b0001, 1'b0);
        for (int c = 0; c < 3; c++) tick(4'b0000, 1'b0);

        // Round-robin between two polite requesters: 3 ack cycles, 1 cycle with rq low.
        hold = '{0, 0, 0, 0};
        prev_ack = '0;
        for (int c = 0; c < 30; c++) begin
            v = 4'b0110;
            for (int i = 1; i <= 2; i++) begin
                if (a_ack[i]) hold[i]++;
                else hold[i] = 0;
                if (hold[i] == 3) v[i] = 1'b0;
            end
            tick(v, 1'b0);
            if (a_ack != '0 && prev_ack == '0) order.push_back(int'(a_idx));
            prev_ack = a_ack;
        end
        check_eq("rr_grants", (order.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
        if (order.size() >= 4) begin
            check_eq("rr_order0", order[0], 1);
            check_eq("rr_order1", order[1], 2);
            check_eq("rr_order2", order[2], 1);
            check_eq("rr_order3", order[3], 2);
        end
        for (int c = 0; c < 3; c++) tick(4'b0000, 1'b0);

        // Priority override, then pointer wraps to 0.
        tick(4'b1011, 1'b0);
        check_eq("prio_first", {28'd0, a_ack}, 32'b1000);
        tick(4'b1011, 1'b0);
        tick(4'b1011, 1'b0);
        tick(4'b0011, 1'b0);
        tick(4'b0011, 1'b0);
        tick(4'b0011, 1'b0);
        check_eq("prio_then_wrap", {28'd0, a_ack}, 32'b0001);
        for (int c = 0; c < 4; c++) tick(4'b0000, 1'b0);

        // Preemption of requester 0 after 16 ack cycles.
        tick(4'b0001, 1'b0);
        n_ack = 1;
        tick(4'b0001, 1'b0);
        n_ack = 2;
        for (int c = 0; c < 40; c++) begin
            tick(4'b0011, 1'b0);
            if (!a_ack[0]) break;
            n_ack++;
        end
        check_eq("preempt_len", n_ack, 16);
        check_eq("preempt_pulse", {28'd0, a_pre}, 32'b0001);
        tick(4'b0011, 1'b0);
        tick(4'b0011, 1'b0);
        check_eq("after_preempt", {28'd0, a_ack}, 32'b0010);
        for (int c = 0; c < 4; c++) tick(4'b0000, 1'b0);

        // Priority holder is never preempted.
        tick(4'b1000, 1'b0);
        n_ack = 1;
        saw_pre = 1'b0;
        for (int c = 0; c < 39; c++) begin
            tick((c < 2) ? 4'b1000 : 4'b1010, 1'b0);
            if (a_ack[3]) n_ack++;
            if (a_pre != '0) saw_pre = 1'b1;
        end
        check_eq("prio_hold_len", n_ack, 40);
        check_eq("prio_no_preempt", {31'd0, saw_pre}, 32'd0);
        tick(4'b0000, 1'b0);
        for (int c = 0; c < 4; c++) tick(4'b0000, 1'b0);

        // Reset mid-grant.
        for (int c = 0; c < 4; c++) tick(4'b0100, 1'b0);
        tick(4'b0100, 1'b1);
        check_eq("rst_ack", {28'd0, a_ack}, 32'd0);
        check_eq("rst_busy", {31'd0, a_busy}, 32'd0);
        check_eq("rst_idx", {30'd0, a_idx}, 32'd0);
        tick(4'b0100, 1'b0);
        check_eq("rst_regrant", {28'd0, a_ack}, 32'b0100);
        for (int c = 0; c < 4; c++) tick(4'b0000, 1'b0);

        // Random traffic; alternate fast and slow toggling so long holds hit preemption.
        v = '0;
        for (int c = 0; c < 4000; c++) begin
            slow = ((c / 500) % 2 == 1) ? 40 : 6;
            for (int i = 0; i < 4; i++) if ($urandom_range(slow - 1, 0) == 0) v[i] = ~v[i];
            tick(v, ($urandom_range(299, 0) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
